// File: rtl/ifm_bram_arbiter.sv
// Single-port IFM BRAM arbiter: one loader writer, two conv read engines.
// Writes win unless a reader has waited out MAX_WR_BURST write grants; readers share round-robin.
module ifm_bram_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned WA_W         = 32,
  parameter int unsigned RA_W         = 20,
  parameter int unsigned DEPTH        = 26912,
  parameter int unsigned MAX_WR_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req_i,
  input  logic [WA_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  input  logic              rd0_req_i,
  input  logic [RA_W-1:0]   rd0_addr_i,
  output logic              rd0_gnt_o,
  output logic              rd0_valid_o,
  output logic [DATA_W-1:0] rd0_data_o,
  input  logic              rd1_req_i,
  input  logic [RA_W-1:0]   rd1_addr_i,
  output logic              rd1_gnt_o,
  output logic              rd1_valid_o,
  output logic [DATA_W-1:0] rd1_data_o,
  output logic              bram_wr_rd_en_o,
  output logic [WA_W-1:0]   bram_wr_addr_o,
  output logic [RA_W-1:0]   bram_rd_addr_o,
  output logic [DATA_W-1:0] bram_data_in_o,
  input  logic [DATA_W-1:0] bram_data_out_i,
  output logic              err_oob_o
);

  localparam int unsigned STREAK_W = $clog2(MAX_WR_BURST + 1);
  localparam int unsigned WIDX_W   = RA_W - 2;

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                rr_q, rr_d;
  logic                tag_valid_q, tag_valid_d;
  logic                tag_id_q, tag_id_d;
  logic                tag_oob_q, tag_oob_d;
  logic                err_oob_q, err_oob_d;

  logic              rd_any, burst_hit, wr_win, wr_gnt, rd_gnt, rd_id;
  logic              wr_oob, rd_oob;
  logic [RA_W-1:0]   rd_addr_sel;

  // Arbitration, BRAM drive and next state
  always_comb begin
    rd_any      = rd0_req_i | rd1_req_i;
    burst_hit   = (streak_q == STREAK_W'(MAX_WR_BURST)) && rd_any;
    wr_win      = wr_req_i && !burst_hit;
    wr_gnt      = rst_n && wr_win;
    rd_gnt      = rst_n && !wr_win && rd_any;
    rd_id       = rr_q ? rd1_req_i : !rd0_req_i;
    rd_addr_sel = rd_id ? rd1_addr_i : rd0_addr_i;
    wr_oob      = wr_addr_i >= WA_W'(DEPTH);
    rd_oob      = rd_addr_sel[RA_W-1:2] >= WIDX_W'(DEPTH);

    rr_d        = rd_gnt ? !rr_q : rr_q;
    streak_d    = streak_q;
    if (rd_gnt || !rd_any) begin
      streak_d = '0;
    end else if (wr_gnt && (streak_q < STREAK_W'(MAX_WR_BURST))) begin
      streak_d = streak_q + STREAK_W'(1);
    end
    tag_valid_d = rd_gnt;
    tag_id_d    = rd_id;
    tag_oob_d   = rd_gnt && rd_oob;
    err_oob_d   = (wr_gnt && wr_oob) || (rd_gnt && rd_oob);
  end

  assign wr_gnt_o        = wr_gnt;
  assign rd0_gnt_o       = rd_gnt && !rd_id;
  assign rd1_gnt_o       = rd_gnt && rd_id;
  assign bram_wr_rd_en_o = wr_gnt && !wr_oob;
  assign bram_wr_addr_o  = wr_gnt ? wr_addr_i : '0;
  assign bram_data_in_o  = wr_gnt ? wr_data_i : '0;
  assign bram_rd_addr_o  = rd_gnt ? rd_addr_sel : '0;

  // Read return follows the tag captured at the grant edge
  assign rd0_valid_o = tag_valid_q && !tag_id_q;
  assign rd1_valid_o = tag_valid_q && tag_id_q;
  assign rd0_data_o  = (rd0_valid_o && !tag_oob_q) ? bram_data_out_i : '0;
  assign rd1_data_o  = (rd1_valid_o && !tag_oob_q) ? bram_data_out_i : '0;
  assign err_oob_o   = err_oob_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q    <= '0;
      rr_q        <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_id_q    <= 1'b0;
      tag_oob_q   <= 1'b0;
      err_oob_q   <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      rr_q        <= rr_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      tag_oob_q   <= tag_oob_d;
      err_oob_q   <= err_oob_d;
    end
  end

endmodule

// File: tb/tb_ifm_bram_arbiter.sv
// Directed bench for ifm_bram_arbiter with a small registered-output BRAM model.
module tb_ifm_bram_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WA_W   = 32;
  localparam int unsigned RA_W   = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_req;
  logic [WA_W-1:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd0_req, rd1_req;
  logic [RA_W-1:0]   rd0_addr, rd1_addr;
  logic              rd0_gnt, rd1_gnt, rd0_valid, rd1_valid;
  logic [DATA_W-1:0] rd0_data, rd1_data;
  logic              bram_en;
  logic [WA_W-1:0]   bram_wr_addr;
  logic [RA_W-1:0]   bram_rd_addr;
  logic [DATA_W-1:0] bram_din, bram_dout;
  logic              err_oob;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifm_bram_arbiter #(.MAX_WR_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
    .rd0_req_i(rd0_req), .rd0_addr_i(rd0_addr), .rd0_gnt_o(rd0_gnt),
    .rd0_valid_o(rd0_valid), .rd0_data_o(rd0_data),
    .rd1_req_i(rd1_req), .rd1_addr_i(rd1_addr), .rd1_gnt_o(rd1_gnt),
    .rd1_valid_o(rd1_valid), .rd1_data_o(rd1_data),
    .bram_wr_rd_en_o(bram_en), .bram_wr_addr_o(bram_wr_addr), .bram_rd_addr_o(bram_rd_addr),
    .bram_data_in_o(bram_din), .bram_data_out_i(bram_dout), .err_oob_o(err_oob)
  );

  // BRAM model: 64 words aliased on low index bits, output zeroed on write cycles
  logic [DATA_W-1:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    bram_dout = '0;
  end
  always @(posedge clk) begin
    if (bram_en) begin
      mem[bram_wr_addr[5:0]] <= bram_din;
      bram_dout <= '0;
    end else begin
      bram_dout <= mem[bram_rd_addr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle; inputs are driven there, checks follow #1 later
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd0_req = 1'b0; rd0_addr = '0;
    rd1_req = 1'b0; rd1_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    #1;
    check("rst_wr_gnt", 32'(wr_gnt), 0);
    check("rst_rd_gnts", {30'b0, rd1_gnt, rd0_gnt}, 0);
    check("rst_valids", {30'b0, rd1_valid, rd0_valid}, 0);
    check("rst_err_oob", 32'(err_oob), 0);
    check("rst_bram_en", 32'(bram_en), 0);
    check("rst_bram_rd_addr", 32'(bram_rd_addr), 0);
    next_cycle();
    rst_n = 1'b1;

    // Write then read back the same word
    next_cycle();
    wr_req = 1'b1; wr_addr = 5; wr_data = 32'hA5A50001;
    #1;
    check("wr_gnt", 32'(wr_gnt), 1);
    check("wr_bram_en", 32'(bram_en), 1);
    check("wr_bram_addr", bram_wr_addr, 5);
    check("wr_bram_din", bram_din, 32'hA5A50001);
    next_cycle();
    idle_inputs();
    rd0_req = 1'b1; rd0_addr = 20'h14;
    #1;
    check("rb_rd0_gnt", 32'(rd0_gnt), 1);
    check("rb_bram_en", 32'(bram_en), 0);
    check("rb_bram_rd_addr", 32'(bram_rd_addr), 32'h14);
    next_cycle();
    rd0_req = 1'b0; rd0_addr = '0;
    #1;
    check("rb_rd0_valid", 32'(rd0_valid), 1);
    check("rb_rd0_data", rd0_data, 32'hA5A50001);
    check("rb_rd1_valid", 32'(rd1_valid), 0);
    check("idle_bram_rd_addr", 32'(bram_rd_addr), 0);

    // Round-robin from reset: 0,1,0,1,0,1 with valids one cycle behind
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      rd0_req = 1'b1; rd0_addr = 20'h14;
      rd1_req = 1'b1; rd1_addr = 20'h14;
      #1;
      check($sformatf("rr_gnt_%0d", i), {30'b0, rd1_gnt, rd0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0)
        check($sformatf("rr_valid_%0d", i), {30'b0, rd1_valid, rd0_valid},
              (i % 2 == 1) ? 32'd1 : 32'd2);
    end
    next_cycle();
    idle_inputs();
    #1;
    check("rr_valid_last", {30'b0, rd1_valid, rd0_valid}, 2);
    check("rr_data_last", rd1_data, 32'hA5A50001);
    check("rr_rd0_data_zero", rd0_data, 0);

    // Starvation guard with MAX_WR_BURST = 4
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      wr_req = 1'b1; wr_addr = 32'(16 + i); wr_data = 32'(i);
      if (i <= 4) begin
        rd1_req = 1'b1; rd1_addr = 20'h14;
      end else begin
        rd1_req = 1'b0; rd1_addr = '0;
      end
      #1;
      check($sformatf("sg_wr_gnt_%0d", i), 32'(wr_gnt), (i == 4) ? 32'd0 : 32'd1);
      check($sformatf("sg_rd1_gnt_%0d", i), 32'(rd1_gnt), (i == 4) ? 32'd1 : 32'd0);
      if (i == 5) begin
        check("sg_rd1_valid", 32'(rd1_valid), 1);
        check("sg_rd1_data", rd1_data, 32'hA5A50001);
      end
    end

    // Out-of-range write then read
    next_cycle();
    idle_inputs();
    wr_req = 1'b1; wr_addr = 26912; wr_data = 32'h12345678;
    #1;
    check("oob_wr_gnt", 32'(wr_gnt), 1);
    check("oob_wr_bram_en", 32'(bram_en), 0);
    next_cycle();
    idle_inputs();
    rd0_req = 1'b1; rd0_addr = 20'h1A480;
    #1;
    check("oob_wr_err", 32'(err_oob), 1);
    check("oob_rd0_gnt", 32'(rd0_gnt), 1);
    next_cycle();
    idle_inputs();
    #1;
    check("oob_rd0_valid", 32'(rd0_valid), 1);
    check("oob_rd0_data", rd0_data, 0);
    check("oob_rd_err", 32'(err_oob), 1);
    next_cycle();
    #1;
    check("oob_err_clear", 32'(err_oob), 0);
    check("inrange_limit_rd_gnt", 32'(rd0_gnt), 0);
    rd0_req = 1'b1; rd0_addr = 20'h1A47C;
    #1;
    next_cycle();
    idle_inputs();
    #1;
    check("last_word_no_err", 32'(err_oob), 0);
    check("last_word_valid", 32'(rd0_valid), 1);

    // Reset during a pending rd1 return
    do_reset();
    rd1_req = 1'b1; rd1_addr = 20'h14;
    #1;
    check("rm_rd1_gnt", 32'(rd1_gnt), 1);
    next_cycle();
    rd0_req = 1'b1; rd0_addr = 20'h14;
    rst_n = 1'b0;
    #1;
    check("rm_rd1_valid_dropped", 32'(rd1_valid), 0);
    check("rm_gnts_in_reset", {30'b0, rd1_gnt, rd0_gnt}, 0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("rm_first_gnt", {30'b0, rd1_gnt, rd0_gnt}, 1);
    check("rm_no_stale_valid", 32'(rd1_valid), 0);
    next_cycle();
    idle_inputs();
    #1;
    check("rm_rd0_valid", 32'(rd0_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
